// File: rtl/bus_split_arbiter.sv
// Two-master / three-slave bus arbiter with split-transaction parking and a hold timeout.
// Every output is a flop; the bus owner, parked master and timeout counter advance on the rising edge.
module bus_split_arbiter #(
    parameter int SLAVE_LEN = 2,
    parameter int TIMEOUT   = 255,
    parameter int CNT_LEN   = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 m1_request,
    input  logic                 m2_request,
    input  logic [SLAVE_LEN-1:0] m1_slave_sel,
    input  logic [SLAVE_LEN-1:0] m2_slave_sel,
    input  logic                 trans_done,
    input  logic                 s1_split_en,
    input  logic                 s2_split_en,
    input  logic                 s3_split_en,
    output logic                 m1_grant,
    output logic                 m2_grant,
    output logic                 arbiter_busy,
    output logic                 bus_busy,
    output logic [SLAVE_LEN-1:0] bus_slave_sel,
    output logic                 split_pending,
    output logic                 timeout
);
    localparam logic [1:0]           ST_IDLE     = 2'd0;
    localparam logic [1:0]           ST_ARB      = 2'd1;
    localparam logic [1:0]           ST_GRANT    = 2'd2;
    localparam logic [SLAVE_LEN-1:0] SEL_INVALID = SLAVE_LEN'(3);
    localparam logic [CNT_LEN-1:0]   CNT_ONE     = CNT_LEN'(1);
    localparam logic [CNT_LEN-1:0]   CNT_LAST    = CNT_LEN'(TIMEOUT - 1);

    // Master ids: 1'b0 = master1, 1'b1 = master2.
    logic [1:0]           state_r, state_nxt_s;
    logic                 owner_r, owner_nxt_s;
    logic                 last_winner_r, last_winner_nxt_s;
    logic                 resumed_r, resumed_nxt_s;
    logic                 parked_master_r, parked_master_nxt_s;
    logic [SLAVE_LEN-1:0] parked_slave_r, parked_slave_nxt_s;
    logic                 split_pending_r, split_pending_nxt_s;
    logic [CNT_LEN-1:0]   cnt_r, cnt_nxt_s;
    logic [SLAVE_LEN-1:0] bus_slave_sel_r, bus_slave_sel_nxt_s;
    logic                 timeout_r, timeout_nxt_s;
    logic                 m1_grant_r, m2_grant_r, arbiter_busy_r, bus_busy_r;

    logic                 m1_elig_s, m2_elig_s, resume_s, owner_done_s, owner_split_s;
    logic                 win_valid_s, win_id_s, win_resume_s;
    logic [SLAVE_LEN-1:0] win_sel_s;

    function automatic logic slave_split(input logic [SLAVE_LEN-1:0] sel,
                                         input logic sp1, input logic sp2, input logic sp3);
        logic hit;
        case (sel)
            SLAVE_LEN'(0): hit = sp1;
            SLAVE_LEN'(1): hit = sp2;
            SLAVE_LEN'(2): hit = sp3;
            default:       hit = 1'b0;
        endcase
        return hit;
    endfunction

    // A parked master may only come back through the resume path, never as a plain requester.
    assign m1_elig_s = m1_request && (m1_slave_sel != SEL_INVALID)
                     && !(split_pending_r && (parked_master_r == 1'b0))
                     && !(split_pending_r && (m1_slave_sel == parked_slave_r));
    assign m2_elig_s = m2_request && (m2_slave_sel != SEL_INVALID)
                     && !(split_pending_r && (parked_master_r == 1'b1))
                     && !(split_pending_r && (m2_slave_sel == parked_slave_r));
    assign resume_s      = split_pending_r
                         && !slave_split(parked_slave_r, s1_split_en, s2_split_en, s3_split_en);
    assign owner_done_s  = trans_done || !(owner_r ? m2_request : m1_request);
    assign owner_split_s = slave_split(bus_slave_sel_r, s1_split_en, s2_split_en, s3_split_en);

    // Winner selection: resume first, then a lone requester, then round-robin on a tie
    always_comb begin
        win_valid_s  = 1'b0;
        win_id_s     = 1'b0;
        win_sel_s    = m1_slave_sel;
        win_resume_s = 1'b0;
        if (resume_s) begin
            win_valid_s  = 1'b1;
            win_id_s     = parked_master_r;
            win_sel_s    = parked_slave_r;
            win_resume_s = 1'b1;
        end else if (m1_elig_s && m2_elig_s) begin
            win_valid_s = 1'b1;
            win_id_s    = ~last_winner_r;
            win_sel_s   = last_winner_r ? m1_slave_sel : m2_slave_sel;
        end else if (m1_elig_s) begin
            win_valid_s = 1'b1;
            win_id_s    = 1'b0;
            win_sel_s   = m1_slave_sel;
        end else if (m2_elig_s) begin
            win_valid_s = 1'b1;
            win_id_s    = 1'b1;
            win_sel_s   = m2_slave_sel;
        end else begin
            win_valid_s = 1'b0;
        end
    end

    // Next-state logic; trans_done outranks split, and split outranks the timeout
    always_comb begin
        state_nxt_s         = state_r;
        owner_nxt_s         = owner_r;
        last_winner_nxt_s   = last_winner_r;
        resumed_nxt_s       = resumed_r;
        parked_master_nxt_s = parked_master_r;
        parked_slave_nxt_s  = parked_slave_r;
        split_pending_nxt_s = split_pending_r;
        cnt_nxt_s           = cnt_r;
        bus_slave_sel_nxt_s = bus_slave_sel_r;
        timeout_nxt_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (resume_s || m1_elig_s || m2_elig_s) begin
                    state_nxt_s = ST_ARB;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ARB: begin
                if (win_valid_s) begin
                    state_nxt_s         = ST_GRANT;
                    owner_nxt_s         = win_id_s;
                    last_winner_nxt_s   = win_id_s;
                    resumed_nxt_s       = win_resume_s;
                    bus_slave_sel_nxt_s = win_sel_s;
                    cnt_nxt_s           = {CNT_LEN{1'b0}};
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_GRANT: begin
                cnt_nxt_s = cnt_r + CNT_ONE;
                if (owner_done_s) begin
                    state_nxt_s   = ST_IDLE;
                    resumed_nxt_s = 1'b0;
                    if (resumed_r) begin
                        split_pending_nxt_s = 1'b0;
                    end else begin
                        split_pending_nxt_s = split_pending_r;
                    end
                end else if (owner_split_s) begin
                    state_nxt_s         = ST_IDLE;
                    resumed_nxt_s       = 1'b0;
                    split_pending_nxt_s = 1'b1;
                    parked_master_nxt_s = owner_r;
                    parked_slave_nxt_s  = bus_slave_sel_r;
                end else if ((TIMEOUT != 0) && (cnt_r == CNT_LAST)) begin
                    state_nxt_s   = ST_IDLE;
                    resumed_nxt_s = 1'b0;
                    timeout_nxt_s = 1'b1;
                end else begin
                    state_nxt_s = ST_GRANT;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State registers plus outputs decoded from the next state so they line up with it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r         <= ST_IDLE;
            owner_r         <= 1'b0;
            last_winner_r   <= 1'b1;
            resumed_r       <= 1'b0;
            parked_master_r <= 1'b0;
            parked_slave_r  <= {SLAVE_LEN{1'b0}};
            split_pending_r <= 1'b0;
            cnt_r           <= {CNT_LEN{1'b0}};
            bus_slave_sel_r <= {SLAVE_LEN{1'b0}};
            timeout_r       <= 1'b0;
            m1_grant_r      <= 1'b0;
            m2_grant_r      <= 1'b0;
            arbiter_busy_r  <= 1'b0;
            bus_busy_r      <= 1'b0;
        end else begin
            state_r         <= state_nxt_s;
            owner_r         <= owner_nxt_s;
            last_winner_r   <= last_winner_nxt_s;
            resumed_r       <= resumed_nxt_s;
            parked_master_r <= parked_master_nxt_s;
            parked_slave_r  <= parked_slave_nxt_s;
            split_pending_r <= split_pending_nxt_s;
            cnt_r           <= cnt_nxt_s;
            bus_slave_sel_r <= bus_slave_sel_nxt_s;
            timeout_r       <= timeout_nxt_s;
            m1_grant_r      <= (state_nxt_s == ST_GRANT) && (owner_nxt_s == 1'b0);
            m2_grant_r      <= (state_nxt_s == ST_GRANT) && (owner_nxt_s == 1'b1);
            arbiter_busy_r  <= (state_nxt_s != ST_IDLE);
            bus_busy_r      <= (state_nxt_s == ST_GRANT);
        end
    end

    assign m1_grant      = m1_grant_r;
    assign m2_grant      = m2_grant_r;
    assign arbiter_busy  = arbiter_busy_r;
    assign bus_busy      = bus_busy_r;
    assign bus_slave_sel = bus_slave_sel_r;
    assign split_pending = split_pending_r;
    assign timeout       = timeout_r;
endmodule

// File: tb/tb_bus_split_arbiter.sv
// Bench for bus_split_arbiter: directed scenarios followed by random traffic, all checked
// against a transaction-level reference model of owner, parked master and hold time.
module tb_bus_split_arbiter;
    localparam int SLAVE_LEN = 2;
    localparam int TIMEOUT   = 4;
    localparam int CNT_LEN   = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       m1_request = 1'b0, m2_request = 1'b0;
    logic [1:0] m1_slave_sel = 2'd0, m2_slave_sel = 2'd0;
    logic       trans_done = 1'b0;
    logic       s1_split_en = 1'b0, s2_split_en = 1'b0, s3_split_en = 1'b0;
    logic       m1_grant, m2_grant, arbiter_busy, bus_busy, split_pending, timeout;
    logic [1:0] bus_slave_sel;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: phase 0 = nobody, 1 = deciding, 2 = owned; park = -1 when nobody is parked.
    int m_phase, m_owner, m_last, m_park, m_park_slave, m_resumed, m_held, m_bus_sel, m_timeout;
    bit drop_next [2];

    always #5 clk = ~clk;

    bus_split_arbiter #(.SLAVE_LEN(SLAVE_LEN), .TIMEOUT(TIMEOUT), .CNT_LEN(CNT_LEN)) dut (
        .clk(clk), .reset(reset),
        .m1_request(m1_request), .m2_request(m2_request),
        .m1_slave_sel(m1_slave_sel), .m2_slave_sel(m2_slave_sel),
        .trans_done(trans_done),
        .s1_split_en(s1_split_en), .s2_split_en(s2_split_en), .s3_split_en(s3_split_en),
        .m1_grant(m1_grant), .m2_grant(m2_grant),
        .arbiter_busy(arbiter_busy), .bus_busy(bus_busy),
        .bus_slave_sel(bus_slave_sel), .split_pending(split_pending), .timeout(timeout)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic int req_of(int m);
        return (m == 0) ? int'(m1_request) : int'(m2_request);
    endfunction

    function automatic int sel_of(int m);
        return (m == 0) ? int'(m1_slave_sel) : int'(m2_slave_sel);
    endfunction

    function automatic bit split_of(int s);
        case (s)
            0: return s1_split_en;
            1: return s2_split_en;
            2: return s3_split_en;
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit eligible(int m);
        if (req_of(m) == 0 || sel_of(m) == 3) return 1'b0;
        if (m_park == m) return 1'b0;
        if (m_park >= 0 && sel_of(m) == m_park_slave) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_owner = 0; m_last = 1; m_park = -1; m_park_slave = 0;
        m_resumed = 0; m_held = 0; m_bus_sel = 0; m_timeout = 0;
    endtask

    // Advance the model by one clock using the inputs the DUT is about to sample.
    task automatic model_step();
        bit res, e0, e1, done;
        int win;
        res = (m_park >= 0) && !split_of(m_park_slave);
        e0 = eligible(0);
        e1 = eligible(1);
        m_timeout = 0;
        if (m_phase == 0) begin
            if (res || e0 || e1) m_phase = 1;
        end else if (m_phase == 1) begin
            win = -1;
            if (res) win = m_park;
            else if (e0 && e1) win = 1 - m_last;
            else if (e0) win = 0;
            else if (e1) win = 1;
            if (win < 0) m_phase = 0;
            else begin
                m_owner = win; m_last = win; m_resumed = int'(res);
                m_bus_sel = res ? m_park_slave : sel_of(win);
                m_held = 0; m_phase = 2;
            end
        end else begin
            done = trans_done || (req_of(m_owner) == 0);
            if (done) begin
                if (m_resumed != 0) m_park = -1;
                m_resumed = 0; m_phase = 0;
            end else if (split_of(m_bus_sel)) begin
                m_park = m_owner; m_park_slave = m_bus_sel; m_resumed = 0; m_phase = 0;
            end else begin
                m_held++;
                if (TIMEOUT != 0 && m_held == TIMEOUT) begin
                    m_timeout = 1; m_resumed = 0; m_phase = 0;
                end
            end
        end
    endtask

    task automatic compare_all();
        check_eq("m1_grant",      32'(m1_grant),      32'(m_phase == 2 && m_owner == 0));
        check_eq("m2_grant",      32'(m2_grant),      32'(m_phase == 2 && m_owner == 1));
        check_eq("bus_busy",      32'(bus_busy),      32'(m_phase == 2));
        check_eq("arbiter_busy",  32'(arbiter_busy),  32'(m_phase != 0));
        check_eq("bus_slave_sel", 32'(bus_slave_sel), 32'(m_bus_sel));
        check_eq("split_pending", 32'(split_pending), 32'(m_park >= 0));
        check_eq("timeout",       32'(timeout),       32'(m_timeout));
        check_eq("grant_excl",    32'(m1_grant & m2_grant), 32'd0);
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic clear_inputs();
        m1_request = 1'b0; m2_request = 1'b0; m1_slave_sel = 2'd0; m2_slave_sel = 2'd0;
        trans_done = 1'b0; s1_split_en = 1'b0; s2_split_en = 1'b0; s3_split_en = 1'b0;
        drop_next[0] = 1'b0; drop_next[1] = 1'b0;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        clear_inputs();
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        compare_all();
    endtask

    task automatic drive_random();
        bit rq;
        logic [1:0] sl;
        trans_done = 1'b0;
        for (int m = 0; m < 2; m++) begin
            rq = (m == 0) ? m1_request : m2_request;
            sl = (m == 0) ? m1_slave_sel : m2_slave_sel;
            if (drop_next[m]) begin
                rq = 1'b0; drop_next[m] = 1'b0;
            end else if (!rq) begin
                if ($urandom_range(0, 2) == 0) begin
                    rq = 1'b1;
                    sl = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
                end
            end else if (m_phase == 2 && m_owner == m) begin
                if ($urandom_range(0, 2) == 0) begin
                    trans_done = 1'b1; drop_next[m] = 1'b1;
                end else if ($urandom_range(0, 39) == 0) begin
                    rq = 1'b0;
                end
            end else if (sl == 2'd3 && $urandom_range(0, 7) == 0) begin
                rq = 1'b0;
            end
            if (m == 0) begin m1_request = rq; m1_slave_sel = sl; end
            else begin m2_request = rq; m2_slave_sel = sl; end
        end
        if (m_phase != 2 && $urandom_range(0, 15) == 0) trans_done = 1'b1;
        s1_split_en = s1_split_en ^ ($urandom_range(0, 9) == 0);
        s2_split_en = s2_split_en ^ ($urandom_range(0, 9) == 0);
        s3_split_en = s3_split_en ^ ($urandom_range(0, 9) == 0);
    endtask

    initial begin
        model_reset();
        apply_reset();
        check_eq("rst_sel", 32'(bus_slave_sel), 32'd0);

        // single master, two-cycle grant latency, release on trans_done
        m1_request = 1'b1; m1_slave_sel = 2'd1;
        tick();
        check_eq("t1_arb", 32'(arbiter_busy), 32'd1);
        check_eq("t1_nogrant", 32'(m1_grant), 32'd0);
        tick();
        check_eq("t1_grant", 32'(m1_grant), 32'd1);
        check_eq("t1_sel", 32'(bus_slave_sel), 32'd1);
        trans_done = 1'b1; tick(); trans_done = 1'b0; m1_request = 1'b0;
        check_eq("t1_release", 32'(m1_grant), 32'd0);
        check_eq("t1_idle", 32'(arbiter_busy), 32'd0);

        // round-robin on repeated ties: m1, m2, m1
        apply_reset();
        for (int r = 0; r < 3; r++) begin
            m1_request = 1'b1; m1_slave_sel = 2'd0; m2_request = 1'b1; m2_slave_sel = 2'd2;
            tick(); tick();
            check_eq("rr_m1", 32'(m1_grant), 32'(r != 1));
            check_eq("rr_m2", 32'(m2_grant), 32'(r == 1));
            trans_done = 1'b1; tick(); trans_done = 1'b0;
            m1_request = 1'b0; m2_request = 1'b0;
            tick();
        end

        // split: park m1 on slave1, serve m2 elsewhere, resume m1 ahead of m2
        apply_reset();
        m1_request = 1'b1; m1_slave_sel = 2'd0;
        tick(); tick();
        check_eq("sp_m1_grant", 32'(m1_grant), 32'd1);
        s1_split_en = 1'b1; tick();
        check_eq("sp_m1_drop", 32'(m1_grant), 32'd0);
        check_eq("sp_pending", 32'(split_pending), 32'd1);
        m2_request = 1'b1; m2_slave_sel = 2'd0;
        for (int i = 0; i < 4; i++) tick();
        check_eq("sp_m2_held", 32'(m2_grant), 32'd0);
        m2_request = 1'b0; tick();
        m2_request = 1'b1; m2_slave_sel = 2'd2;
        tick(); tick();
        check_eq("sp_m2_other", 32'(m2_grant), 32'd1);
        s1_split_en = 1'b0; tick();
        check_eq("sp_no_preempt", 32'(m2_grant), 32'd1);
        trans_done = 1'b1; tick(); trans_done = 1'b0;
        tick(); tick();
        check_eq("sp_resume", 32'(m1_grant), 32'd1);
        check_eq("sp_resume_m2", 32'(m2_grant), 32'd0);
        check_eq("sp_pend_hold", 32'(split_pending), 32'd1);
        check_eq("sp_resume_sel", 32'(bus_slave_sel), 32'd0);
        trans_done = 1'b1; tick(); trans_done = 1'b0; m1_request = 1'b0;
        check_eq("sp_clear", 32'(split_pending), 32'd0);
        tick(); tick();
        check_eq("sp_m2_after", 32'(m2_grant), 32'd1);
        trans_done = 1'b1; tick(); trans_done = 1'b0; m2_request = 1'b0;
        tick();

        // hold timeout after TIMEOUT granted cycles
        apply_reset();
        m2_request = 1'b1; m2_slave_sel = 2'd1;
        tick(); tick();
        check_eq("to_grant", 32'(m2_grant), 32'd1);
        for (int i = 0; i < TIMEOUT - 1; i++) begin
            tick();
            check_eq("to_hold", 32'(m2_grant), 32'd1);
            check_eq("to_nopulse", 32'(timeout), 32'd0);
        end
        tick();
        check_eq("to_drop", 32'(m2_grant), 32'd0);
        check_eq("to_pulse", 32'(timeout), 32'd1);
        check_eq("to_not_parked", 32'(split_pending), 32'd0);
        m2_request = 1'b0; tick();
        check_eq("to_single", 32'(timeout), 32'd0);

        // invalid select is never granted
        apply_reset();
        m1_request = 1'b1; m1_slave_sel = 2'd3; m2_request = 1'b1; m2_slave_sel = 2'd1;
        tick(); tick();
        check_eq("s3_m2", 32'(m2_grant), 32'd1);
        check_eq("s3_m1_none", 32'(m1_grant), 32'd0);
        trans_done = 1'b1; tick(); trans_done = 1'b0; m2_request = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            check_eq("s3_never", 32'(m1_grant), 32'd0);
            check_eq("s3_ignored", 32'(arbiter_busy), 32'd0);
        end
        m1_request = 1'b0;

        // asynchronous reset while m2 owns the bus and m1 is parked
        apply_reset();
        m1_request = 1'b1; m1_slave_sel = 2'd0;
        tick(); tick();
        s1_split_en = 1'b1; tick();
        m2_request = 1'b1; m2_slave_sel = 2'd1;
        tick(); tick();
        check_eq("ar_pre", 32'(m2_grant), 32'd1);
        check_eq("ar_pre_split", 32'(split_pending), 32'd1);
        #2 reset = 1'b1;
        #1;
        check_eq("ar_m1", 32'(m1_grant), 32'd0);
        check_eq("ar_m2", 32'(m2_grant), 32'd0);
        check_eq("ar_abusy", 32'(arbiter_busy), 32'd0);
        check_eq("ar_bbusy", 32'(bus_busy), 32'd0);
        check_eq("ar_split", 32'(split_pending), 32'd0);
        check_eq("ar_sel", 32'(bus_slave_sel), 32'd0);
        clear_inputs();
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        compare_all();
        m1_request = 1'b1; m1_slave_sel = 2'd0; m2_request = 1'b1; m2_slave_sel = 2'd2;
        tick(); tick();
        check_eq("ar_tie_m1", 32'(m1_grant), 32'd1);
        trans_done = 1'b1; tick(); trans_done = 1'b0;
        m1_request = 1'b0; m2_request = 1'b0;
        tick();

        // random traffic against the model
        apply_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            drive_random();
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
